// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and CE/OE/WE timing sequencer for a single asynchronous SRAM.
// Define SRAM_ARB_FIXPRI_EN to replace round-robin with fixed priority (A beats B).
module sram_arbiter #(
    parameter int AW       = 18,
    parameter int DW       = 16,
    parameter int WAIT_CYC = 2
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    // Requester handshake: req is raised with we/addr/wdata stable and held
    // until the one-cycle ack; those inputs are only looked at while IDLE, so
    // a req still high in the cycle after ack is taken as a new request.
    input  logic          req_a,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] wdata_a,
    output logic          ack_a,
    output logic [DW-1:0] rdata_a,
    input  logic          req_b,
    input  logic          we_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_b,
    output logic          ack_b,
    output logic [DW-1:0] rdata_b,
    output logic [AW-1:0] sram_addr,
    inout  wire  [DW-1:0] sram_dq,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n,
    output logic [1:0]    fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYC - 1);

    state_t        state, state_nx;
    logic [3:0]    cnt, cnt_nx;
    logic          gnt_b;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic          dq_oe;

    logic          pick_b;
    logic          grant;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          nx_we;
    logic          nx_gnt_b;
    logic          ce_n_nx, oe_n_nx, we_n_nx, dq_oe_nx;
    logic          ack_a_nx, ack_b_nx;
    logic          capture_rd;

`ifdef SRAM_ARB_FIXPRI_EN
    assign pick_b = !req_a;
`else
    // rr_prio_b set means B was not granted last and wins a conflict.
    logic rr_prio_b;
    assign pick_b = req_b && (!req_a || rr_prio_b);
`endif

    assign sel_we    = pick_b ? we_b    : we_a;
    assign sel_addr  = pick_b ? addr_b  : addr_a;
    assign sel_wdata = pick_b ? wdata_b : wdata_a;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        grant    = 1'b0;
        case (state)
            IDLE: begin
                if (req_a || req_b) begin
                    grant    = 1'b1;
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                cnt_nx   = 4'd0;
                state_nx = ACCESS;
            end
            ACCESS: begin
                if (cnt == CNT_LAST) begin
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Strobes are registered from the next state so the pins never glitch.
        nx_we      = grant ? sel_we : lat_we;
        nx_gnt_b   = grant ? pick_b : gnt_b;
        ce_n_nx    = (state_nx == IDLE);
        oe_n_nx    = !((state_nx == ACCESS) && !nx_we);
        we_n_nx    = !((state_nx == ACCESS) && nx_we);
        dq_oe_nx   = (state_nx != IDLE) && nx_we;
        ack_a_nx   = (state_nx == DONE) && !nx_gnt_b;
        ack_b_nx   = (state_nx == DONE) && nx_gnt_b;
        capture_rd = (state == ACCESS) && (cnt == CNT_LAST) && !lat_we;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            gnt_b     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            dq_oe     <= 1'b0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            ack_a     <= 1'b0;
            ack_b     <= 1'b0;
            rdata_a   <= '0;
            rdata_b   <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            gnt_b     <= nx_gnt_b;
            dq_oe     <= dq_oe_nx;
            sram_ce_n <= ce_n_nx;
            sram_oe_n <= oe_n_nx;
            sram_we_n <= we_n_nx;
            ack_a     <= ack_a_nx;
            ack_b     <= ack_b_nx;
            if (grant) begin
                lat_we    <= sel_we;
                lat_addr  <= sel_addr;
                lat_wdata <= sel_wdata;
            end
            if (capture_rd && !gnt_b) begin
                rdata_a <= sram_dq;
            end
            if (capture_rd && gnt_b) begin
                rdata_b <= sram_dq;
            end
        end
    end

`ifndef SRAM_ARB_FIXPRI_EN
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            rr_prio_b <= 1'b0;
        end else if (grant) begin
            rr_prio_b <= !pick_b;
        end
    end
`endif

    // Address and write data stay on the pins from SETUP through DONE for hold time.
    assign sram_addr = lat_addr;
    assign sram_dq   = dq_oe ? lat_wdata : {DW{1'bz}};
    assign fsm_state = state;

endmodule
